// File: rtl/mem_access_pkg.sv
// Shared Y86-64 icode constants and the memory-stage FSM state type.
// Execute and fetch import the same icode constants.
package mem_access_pkg;

  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StDone
  } mem_state_e;

  function automatic logic icode_writes(input logic [3:0] icode);
    return (icode == I_RMMOVQ) || (icode == I_PUSHQ) || (icode == I_CALL);
  endfunction

  function automatic logic icode_reads(input logic [3:0] icode);
    return (icode == I_MRMOVQ) || (icode == I_RET) || (icode == I_POPQ);
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Byte-wide data RAM: asynchronous read port, synchronous write port.
// Contents are not reset.
module dmem_byte_ram #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned ADDR_W    = $clog2(MEM_BYTES)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_access.sv
// Multi-cycle data-memory stage: one byte per beat, little-endian, start/busy/done handshake.
// Optional feature: define MEM_ACCESS_BOUNDS_CHECK_EN to fault on out-of-range addresses.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output logic        busy,
  output logic        done,
  output logic [63:0] valM,
  output logic        dmem_error
);

  localparam int unsigned AddrW = $clog2(MEM_BYTES);

  mem_state_e       state_q;
  logic [2:0]       k_q;
  logic             is_write_q;
  logic [AddrW-1:0] addr_q;
  logic [63:0]      wdata_q;
  logic [55:0]      shadow_q;

  logic [63:0]      addr_in;
  logic             access_in;
  logic             fault_in;
  logic [AddrW-1:0] ram_addr;
  logic             ram_we;
  logic [7:0]       ram_wdata;
  logic [7:0]       ram_rdata;

  assign addr_in   = ((icode == I_RET) || (icode == I_POPQ)) ? valA : valE;
  assign access_in = icode_writes(icode) || icode_reads(icode);

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
  assign fault_in = access_in && (addr_in > 64'(MEM_BYTES - 8));
`else
  // Without the check the address wraps, so only the low bits matter.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_in[63:AddrW];
  assign fault_in       = 1'b0;
`endif

  assign ram_addr  = addr_q + AddrW'(k_q);
  assign ram_we    = (state_q == StXfer) && is_write_q;
  assign ram_wdata = wdata_q[{k_q, 3'b000} +: 8];

  dmem_byte_ram #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (AddrW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      k_q        <= 3'd0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      shadow_q   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      valM       <= '0;
      dmem_error <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy       <= 1'b1;
            dmem_error <= fault_in;
            is_write_q <= icode_writes(icode);
            addr_q     <= addr_in[AddrW-1:0];
            wdata_q    <= (icode == I_CALL) ? valP : valA;
            k_q        <= 3'd0;
            if (access_in && !fault_in) begin
              state_q <= StXfer;
            end else begin
              state_q <= StDone;
              done    <= 1'b1;
              if (fault_in) begin
                valM <= '0;
              end
            end
          end
        end
        StXfer: begin
          // Bytes shift in from the top so byte 0 ends up lowest after seven beats.
          shadow_q <= {ram_rdata, shadow_q[55:8]};
          k_q      <= k_q + 3'd1;
          if (k_q == 3'd7) begin
            state_q <= StDone;
            done    <= 1'b1;
            if (!is_write_q) begin
              valM <= {ram_rdata, shadow_q};
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
